// File: rtl/float_div_b.sv
// Blocking IEEE-754 single-precision divider (dout = din1 / din2), restoring,
// one quotient bit per cycle, valid/ready on both sides.
module float_div_b #(
  parameter int unsigned BYPASS_ZERO = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_dz,
  output logic        dout_valid,
  input  logic        dout_ready
);

  localparam int unsigned MW = 24;  // mantissa with hidden bit
  localparam int unsigned RW = 26;  // remainder
  localparam int unsigned QW = 27;  // quotient bits produced
  localparam int unsigned CW = 5;   // iteration counter
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   r_q, r_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [MW-1:0]   m2_q, m2_d;
  logic [7:0]      exp_q, exp_d;
  logic            sign_q, sign_d;
  logic            z1_q, z1_d;
  logic            z2_q, z2_d;
  logic [31:0]     dout_q, dout_d;
  logic            dz_q, dz_d;
  logic            valid_q, valid_d;

  logic            in_z1, in_z2;
  logic [RW:0]     t;
  logic [22:0]     man_pre;
  logic            g, s, up;
  logic [MW-1:0]   man_sum;
  logic [7:0]      exp_rnd;

  assign din_ready  = (state_q == IDLE);
  assign dout       = dout_q;
  assign dout_dz    = dz_q;
  assign dout_valid = valid_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      m2_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
      dout_q  <= '0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      m2_q    <= m2_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      dout_q  <= dout_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    quo_d   = quo_q;
    m2_d    = m2_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    dout_d  = dout_q;
    dz_d    = dz_q;
    valid_d = valid_q;

    in_z1 = (din1[30:23] == 8'd0);
    in_z2 = (din2[30:23] == 8'd0);

    // Trial subtraction for one restoring step
    t = {1'b0, r_q} - (RW + 1)'(m2_q);

    // Round to nearest even; normalisation depends on the quotient MSB
    if (quo_q[QW-1]) begin
      man_pre = quo_q[25:3];
      g       = quo_q[2];
      s       = (|quo_q[1:0]) | (r_q != '0);
      exp_rnd = exp_q;
    end else begin
      man_pre = quo_q[24:2];
      g       = quo_q[1];
      s       = quo_q[0] | (r_q != '0);
      exp_rnd = exp_q - 8'd1;
    end
    up      = g & (s | man_pre[0]);
    man_sum = {1'b0, man_pre} + MW'(up);
    exp_rnd = exp_rnd + 8'(man_sum[MW-1]);

    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sign_d  = din1[31] ^ din2[31];
          exp_d   = din1[30:23] - din2[30:23] + 8'd127;
          r_d     = RW'({~in_z1, din1[22:0]});
          m2_d    = {~in_z2, din2[22:0]};
          quo_d   = '0;
          z1_d    = in_z1;
          z2_d    = in_z2;
          state_d = DIV;
          // Zero operands skip the iterations; the single DIV cycle left puts
          // the result 2 cycles after accept.
          cnt_d   = ((BYPASS_ZERO != 0) && (in_z1 || in_z2)) ? LAST_CNT : '0;
        end
      end
      DIV: begin
        if (!t[RW]) begin
          r_d   = RW'(t << 1);
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          r_d   = {r_q[RW-2:0], 1'b0};
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) state_d = ROUND;
      end
      ROUND: begin
        if (z2_q)      dout_d = {sign_q, 8'hFF, 23'h0};
        else if (z1_q) dout_d = 32'h0;
        else           dout_d = {sign_q, exp_rnd, man_sum[22:0]};
        dz_d    = z2_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_float_div_b.sv
// Directed self-checking bench for float_div_b (BYPASS_ZERO=1).
module tb_float_div_b;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] din1, din2;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_dz;
  logic        dout_valid;
  logic        dout_ready;

  int checks = 0;
  int errors = 0;

  float_div_b #(.BYPASS_ZERO(1)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .din1       (din1),
    .din2       (din2),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_dz    (dout_dz),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, measure latency, check result; optionally retire it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_dz, input int exp_lat,
                        input bit retire);
    int lat;
    check({tag, "_din_ready"}, 32'(din_ready), 32'd1);
    din1 = a; din2 = b; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din1 = 32'hDEADBEEF; din2 = 32'h12345678;
    lat = 0;
    while (!dout_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dout"}, dout, exp_d);
    check({tag, "_dz"}, 32'(dout_dz), 32'(exp_dz));
    if (retire) begin
      dout_ready = 1'b1;
      @(posedge clk); #1;
      dout_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(din_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(dout_valid), 32'd0);
    end
  endtask

  initial begin
    nrst = 1'b0; din1 = '0; din2 = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #12;
    check("rst_dout", dout, 32'h0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dz", 32'(dout_dz), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    run_op("6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 1'b1);
    run_op("1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, 1'b1);
    run_op("m10div4",  32'hC1200000, 32'h40800000, 32'hC0200000, 1'b0, 28, 1'b1);
    run_op("9divm3",   32'h41100000, 32'hC0400000, 32'hC0400000, 1'b0, 28, 1'b1);
    run_op("7div7",    32'h40E00000, 32'h40E00000, 32'h3F800000, 1'b0, 28, 1'b1);
    run_op("0div3",    32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 2,  1'b1);
    run_op("m0div3",   32'h80000000, 32'h40400000, 32'h00000000, 1'b0, 2,  1'b1);
    run_op("denormdiv3", 32'h00400000, 32'h40400000, 32'h00000000, 1'b0, 2, 1'b1);
    run_op("1divm0",   32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 2,  1'b1);
    run_op("0div0",    32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 2,  1'b1);

    // Backpressure: result held, inputs ignored while in DONE
    run_op("bp", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 1'b0);
    din1 = 32'h3F800000; din2 = 32'h40400000; din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_dout", dout, 32'h40400000);
      check("bp_valid", 32'(dout_valid), 32'd1);
      check("bp_din_ready", 32'(din_ready), 32'd0);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check("bp_release_ready", 32'(din_ready), 32'd1);
    check("bp_release_valid", 32'(dout_valid), 32'd0);
    run_op("bp_next", 32'hC1200000, 32'h40800000, 32'hC0200000, 1'b0, 28, 1'b1);

    // Reset mid-division aborts the op
    din1 = 32'h3F800000; din2 = 32'h40400000; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("abort_busy", 32'(din_ready), 32'd0);
    nrst = 1'b0;
    #1;
    check("abort_valid", 32'(dout_valid), 32'd0);
    check("abort_dout", dout, 32'h0);
    check("abort_din_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("abort_no_result", 32'(dout_valid), 32'd0);
    run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
